inv_round: RTL
==============

// Module: inv_round
// PURPOSE
//  Multi-cycle AES inverse (decryption) round. It undoes the forward round block: InvShiftRows ->
//  InvSubBytes -> AddRoundKey -> InvMixColumns. InvMixColumns is skipped when 'last' is set.
//  Operands are captured on a valid/ready handshake; the result is held until the consumer takes it.
//  The key schedule / decrypt controller drives this block once per round.
// PARAMETERS
//  none (AES-128 state fixed: 4x4 bytes)
// PORTS
//  clk       in   1        clock; all state changes on posedge
//  rst       in   1        synchronous, active-low reset (sampled on posedge clk)
//  in_valid  in   1        roundin/key/last valid this cycle
//  in_ready  out  1        block can accept operands (high only in IDLE)
//  last      in   1        1 = final decrypt round, InvMixColumns bypassed
//  roundin   in   8x[3:0][3:0]  input state, [row][col], FIPS-197 row/column numbering
//  key       in   8x[3:0][3:0]  round key, same layout
//  roundout  out  8x[3:0][3:0]  result state, same layout
//  out_valid out  1        roundout holds a finished result
//  out_ready in   1        consumer takes result this cycle
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, in_ready=1, out_valid=0, roundout=all 8'h00,
//    internal state/key/last registers cleared. Reset wins over every other event, in any state.
//  FSM: IDLE -> ISUB -> ARK -> (IMC if !last) -> DONE -> IDLE
//   IDLE: in_ready=1. On in_valid, capture roundin, key and last; go to ISUB.
//   ISUB: st[r][c] <= InvSbox(st[r][(c-r) mod 4]). InvShiftRows and InvSubBytes run in one cycle.
//   ARK:  st <= st ^ key_reg, bytewise. Next state is IMC, or DONE when last_reg=1.
//   IMC:  per column c, GF(2^8) with poly 0x11b:
//         [0e 0b 0d 09; 09 0e 0b 0d; 0d 09 0e 0b; 0b 0d 09 0e]*col. Next state is DONE.
//   DONE: roundout=st and out_valid=1. On out_ready, out_valid<=0 and go to IDLE.
//  Latency from accept edge to out_valid=1: 4 cycles (last=0), 3 cycles (last=1).
//  Throughput: one round per 5 cycles (last=0) or 4 cycles (last=1), including the DONE handoff.
//  roundout is registered and updates only on the DONE entry edge.
//  roundout keeps its value after handoff until the next DONE entry.
//  in_valid outside IDLE is ignored: no capture, inputs may change freely.
//  Inputs sampled only at the accept edge; later changes to roundin/key/last do not affect result.
//  out_ready while out_valid=0 has no effect. Result is held indefinitely while out_ready=0.
//  No back-to-back accept in the DONE cycle: in_ready goes high the cycle after handoff.
//  Inverse S-box: 256-entry combinational ROM, 16 instances, no extra latency.
// TESTING
//  T1 reset: hold rst=0 for 2 clks with in_valid=1 -> in_ready=1, out_valid=0, roundout all 00.
//  T2 inv S-box: roundin all 00, key all 00, last=1 -> after 3 clks out_valid=1, roundout all 52.
//  T3 inv shift: roundin all 63 except [1][0]=00, key 00, last=1
//     -> roundout all 00 except [1][1]=52.
//  T4 InvMixColumns: roundin all 63, key col0 rows0..3={8e,4d,a1,bc}, other bytes 00, last=0
//     -> after 4 clks col0 rows0..3={db,13,53,45}, other bytes 00.
//  T5 uniform key: roundin all 63, key all 5a, last=0 -> roundout all 5a.
//     Hold out_ready=0 for 5 clks: out_valid stays 1, roundout stable, in_ready=0.
//  T6 reset mid-op: accept an operand, drop rst=0 during the IMC cycle
//     -> next edge IDLE, out_valid=0, roundout 00. A new T2 operand then completes correctly.

Source files
------------

// File: rtl/inv_round_if.sv
// Handshake and data bundle for the inverse AES round block.
// The master drives operands and takes results; the slave is the round engine.
interface inv_round_if;
   logic                  in_valid;
   logic                  in_ready;
   logic                  last;
   logic [3:0][3:0][7:0]  roundin;
   logic [3:0][3:0][7:0]  key;
   logic [3:0][3:0][7:0]  roundout;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_valid, last, roundin, key, out_ready,
      input  in_ready, roundout, out_valid
   );

   modport slave (
      input  in_valid, last, roundin, key, out_ready,
      output in_ready, roundout, out_valid
   );
endinterface

// File: rtl/inv_round.sv
// Multi-cycle AES-128 inverse round: InvShiftRows+InvSubBytes, AddRoundKey,
// then InvMixColumns unless the operand is flagged as the final round.
module inv_round (
   input  logic        clk,
   input  logic        rst,
   inv_round_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ISUB = 3'd1,
      S_ARK  = 3'd2,
      S_IMC  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   localparam logic [7:0] INV_SBOX [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Products by the InvMixColumns coefficients, built from x2/x4/x8 chains.
   function automatic logic [7:0] mul_9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] mul_b(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] mul_d(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] mul_e(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   state_e               state_q, state_d;
   logic [3:0][3:0][7:0] st_q, st_d;
   logic [3:0][3:0][7:0] key_q, key_d;
   logic                 last_q, last_d;
   logic [3:0][3:0][7:0] roundout_q, roundout_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;

   logic [3:0][3:0][7:0] isub_s;
   logic [3:0][3:0][7:0] ark_s;
   logic [3:0][3:0][7:0] imc_s;

   // Datapath for each round step, all computed from the working state register.
   always_comb begin
      isub_s = '0;
      ark_s  = '0;
      imc_s  = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            isub_s[2'(r)][2'(c)] = inv_sbox(st_q[2'(r)][2'(c - r)]);
            ark_s[2'(r)][2'(c)]  = st_q[2'(r)][2'(c)] ^ key_q[2'(r)][2'(c)];
            imc_s[2'(r)][2'(c)]  = mul_e(st_q[2'(r)][2'(c)])     ^ mul_b(st_q[2'(r + 1)][2'(c)]) ^
                                   mul_d(st_q[2'(r + 2)][2'(c)]) ^ mul_9(st_q[2'(r + 3)][2'(c)]);
         end
      end
   end

   // Next-state and next-output logic of the round sequencer.
   always_comb begin
      state_d     = state_q;
      st_d        = st_q;
      key_d       = key_q;
      last_d      = last_q;
      roundout_d  = roundout_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               st_d    = bus.roundin;
               key_d   = bus.key;
               last_d  = bus.last;
               state_d = S_ISUB;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISUB: begin
            st_d    = isub_s;
            state_d = S_ARK;
         end
         S_ARK: begin
            st_d = ark_s;
            if (last_q) begin
               roundout_d  = ark_s;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               state_d = S_IMC;
            end
         end
         S_IMC: begin
            st_d        = imc_s;
            roundout_d  = imc_s;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
      in_ready_d = (state_d == S_IDLE);
   end

   // State and output registers; reset clears everything and wins in any state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         st_q        <= '0;
         key_q       <= '0;
         last_q      <= 1'b0;
         roundout_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         st_q        <= st_d;
         key_q       <= key_d;
         last_q      <= last_d;
         roundout_q  <= roundout_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign bus.roundout  = roundout_q;
   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = in_ready_q;

endmodule
